// File: rtl/select_mask_pkg.sv
// select_mask_pkg: shared state type and sizing constants for the select mask writer
package select_mask_pkg;
    localparam int MASK_DEPTH = 256;
    localparam int ADDR_W     = 8;
    localparam int NUM_CH     = 3;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
endpackage

// File: rtl/select_window_cmp.sv
// select_window_cmp: inclusive address window test, wrapping when start > end
import select_mask_pkg::*;
module select_window_cmp (
    input  logic [ADDR_W-1:0] i_start,
    input  logic [ADDR_W-1:0] i_end,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit
);
    // A reversed window covers the top of the space and wraps back to the bottom
    always_comb
        o_hit = (i_start <= i_end) ? (i_addr >= i_start && i_addr <= i_end)
                                   : (i_addr >= i_start || i_addr <= i_end);
endmodule

// File: rtl/select_mask_writer.sv
// select_mask_writer: writes a 256-entry, 3-channel window mask on each request;
// SELECT_MASK_COUNT_EN adds per-channel population counts of the last pass.
import select_mask_pkg::*;
module select_mask_writer (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_position_1,
    input  logic [ADDR_W-1:0] start_position_2,
    input  logic [ADDR_W-1:0] start_position_3,
    input  logic [ADDR_W-1:0] end_position_1,
    input  logic [ADDR_W-1:0] end_position_2,
    input  logic [ADDR_W-1:0] end_position_3,
    input  logic              position_3_error_sig,
    input  logic              position_gen_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NUM_CH-1:0] wr_data,
    output logic              rd_ready,
`ifdef SELECT_MASK_COUNT_EN
    output logic [8:0]        mask_count_1,
    output logic [8:0]        mask_count_2,
    output logic [8:0]        mask_count_3,
`endif
    output logic              busy
);
    state_t            r_state, w_next;
    logic              r_gen_d, r_pend, r_err3;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start [NUM_CH];
    logic [ADDR_W-1:0] r_end   [NUM_CH];
    logic [ADDR_W-1:0] w_start [NUM_CH];
    logic [ADDR_W-1:0] w_end   [NUM_CH];
    logic [NUM_CH-1:0] w_hit;
    logic              w_rise, w_last, w_enter, w_busy;

    assign w_start = '{start_position_1, start_position_2, start_position_3};
    assign w_end   = '{end_position_1, end_position_2, end_position_3};
    assign w_rise  = position_gen_en & ~r_gen_d;
    assign w_busy  = r_state == WRITE;
    assign w_last  = w_busy && r_addr == ADDR_W'(MASK_DEPTH - 1);

    // Enter a pass on a fresh rise outside WRITE, or chain straight into one at the end of a pass if requested
    always_comb begin
        w_enter = w_busy ? (w_last & (r_pend | w_rise)) : w_rise;
        w_next  = w_enter ? WRITE : (w_last ? DONE : r_state);
    end

    // State, address counter, pending request and the positions frozen for the current pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gen_d <= 1'b0;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_err3  <= 1'b0;
            r_start <= '{default: '0};
            r_end   <= '{default: '0};
        end else begin
            r_state <= w_next;
            r_gen_d <= position_gen_en;
            r_pend  <= w_enter ? 1'b0 : (r_pend | (w_busy & w_rise));
            r_addr  <= w_enter ? '0 : (w_busy ? r_addr + 1'b1 : r_addr);
            if (w_enter) begin
                r_start <= w_start;
                r_end   <= w_end;
                r_err3  <= position_3_error_sig;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
        select_window_cmp u_cmp (
            .i_start(r_start[k]),
            .i_end  (r_end[k]),
            .i_addr (r_addr),
            .o_hit  (w_hit[k])
        );
    end

    assign wr_en    = w_busy;
    assign busy     = w_busy;
    assign rd_ready = r_state == DONE;
    assign wr_addr  = w_busy ? r_addr : '0;
    assign wr_data  = w_busy ? (w_hit & {~r_err3, 2'b11}) : '0;

`ifdef SELECT_MASK_COUNT_EN
    logic [8:0] r_acc [NUM_CH];
    logic [8:0] r_cnt [NUM_CH];

    // Accumulate ones during the pass and publish the totals as the last address is written
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '{default: '0};
            r_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_last) r_cnt[i] <= r_acc[i] + 9'(wr_data[i]);
                r_acc[i] <= w_enter ? 9'd0 : (w_busy ? r_acc[i] + 9'(wr_data[i]) : r_acc[i]);
            end
        end
    end

    assign mask_count_1 = r_cnt[0];
    assign mask_count_2 = r_cnt[1];
    assign mask_count_3 = r_cnt[2];
`endif
endmodule
